// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared constants and types for the instruction memory arbiter.
package imem_arb_pkg;

    localparam logic [3:0]  EXC_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0]  EXC_IACCESS_FAULT  = 4'd1;
    localparam logic [31:0] NOP                = 32'h0000_0013;

    typedef enum logic {RUN, LOCK} state_t;

    typedef struct packed {
        logic        pend;
        logic        flush;
        logic        fault;
        logic [3:0]  code;
        logic [63:0] val;
    } if_pend_t;

    typedef struct packed {
        logic pend;
        logic err;
        logic rd;
    } ld_pend_t;

endpackage

// File: rtl/imem_arb_if.sv
// imem_arb_if: fetch, loader and memory signals of the instruction memory arbiter.
interface imem_arb_if #(parameter int MEM_SIZE = 2048);

    localparam int IW = $clog2(MEM_SIZE);

    logic          if_req_valid;
    logic          if_req_ready;
    logic [63:0]   if_req_addr;
    logic          if_flush;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;
    logic          if_rsp_exc_en;
    logic [3:0]    if_rsp_exc_code;
    logic [63:0]   if_rsp_exc_val;
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic          ld_req_we;
    logic [63:0]   ld_req_addr;
    logic [31:0]   ld_req_wdata;
    logic          ld_lock;
    logic          ld_rsp_valid;
    logic [31:0]   ld_rsp_data;
    logic          ld_rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_lock,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_exc_en, if_rsp_exc_code, if_rsp_exc_val,
        output ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata, ld_lock,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_exc_en, if_rsp_exc_code, if_rsp_exc_val,
        input  ld_req_ready, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface

// File: rtl/imem_addr_chk.sv
// imem_addr_chk: word alignment and range check of a byte address, plus word index.
module imem_addr_chk #(
    parameter int MEM_SIZE = 2048
) (
    input  logic [63:0]                 addr,
    output logic                        misalign,
    output logic                        oor,
    output logic [$clog2(MEM_SIZE)-1:0] idx
);

    always_comb begin
        misalign = addr[1:0] != 2'b00;
        oor      = addr[63:2] >= 62'(MEM_SIZE);
        idx      = addr[2 +: $clog2(MEM_SIZE)];
    end

endmodule

// File: rtl/imem_arb.sv
// imem_arb: arbitrates fetch and loader access to a single-port instruction memory,
// with fetch priority, loader starvation guard, exclusive loader lock and fault reporting.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int MEM_SIZE   = 2048,
    parameter int STARVE_MAX = 4
) (
    input logic       clk,
    input logic       rst_n,
    imem_arb_if.slave bus
);

    localparam int             IW   = $clog2(MEM_SIZE);
    localparam int             SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    if_pend_t      ifp_q, ifp_d;
    ld_pend_t      ldp_q, ldp_d;
    logic          if_mis, if_oor, ld_mis, ld_oor;
    logic [IW-1:0] if_idx, ld_idx;
    logic          starved, if_gnt, ld_gnt, if_ok, ld_ok, if_out, if_exc;

    imem_addr_chk #(.MEM_SIZE(MEM_SIZE)) u_if_chk (
        .addr(bus.if_req_addr), .misalign(if_mis), .oor(if_oor), .idx(if_idx)
    );

    imem_addr_chk #(.MEM_SIZE(MEM_SIZE)) u_ld_chk (
        .addr(bus.ld_req_addr), .misalign(ld_mis), .oor(ld_oor), .idx(ld_idx)
    );

    always_comb begin
        starved          = starve_q == SMAX;
        // readies are held low during reset so nothing can be granted then
        bus.if_req_ready = rst_n && state_q == RUN && !starved;
        bus.ld_req_ready = rst_n && (state_q == LOCK || !bus.if_req_valid || starved);
        if_gnt           = bus.if_req_valid && bus.if_req_ready;
        ld_gnt           = bus.ld_req_valid && bus.ld_req_ready;
        if_ok            = if_gnt && !(if_mis || if_oor);
        ld_ok            = ld_gnt && !(ld_mis || ld_oor);
        bus.mem_en       = if_ok || ld_ok;
        bus.mem_we       = ld_ok && bus.ld_req_we;
        bus.mem_idx      = if_gnt ? if_idx : ld_idx;
        bus.mem_wdata    = ld_ok ? bus.ld_req_wdata : '0;
        starve_d         = (!bus.ld_req_valid || ld_gnt) ? '0 : starved ? starve_q : starve_q + 1'b1;
        state_d          = state_q == RUN ? ((bus.ld_lock && !ifp_q.pend) ? LOCK : RUN)
                                          : (bus.ld_lock ? LOCK : RUN);
        ifp_d            = '{pend: if_gnt, flush: bus.if_flush, fault: if_gnt && !if_ok,
                             code: if_mis ? EXC_IADDR_MISALIGN : EXC_IACCESS_FAULT,
                             val: bus.if_req_addr};
        ldp_d            = '{pend: ld_gnt, err: ld_gnt && !ld_ok, rd: ld_ok && !bus.ld_req_we};
        // a flush at either the grant or the response cycle drops the response
        if_out               = ifp_q.pend && !ifp_q.flush && !bus.if_flush;
        if_exc               = if_out && ifp_q.fault;
        bus.if_rsp_valid     = if_out;
        bus.if_rsp_exc_en    = if_exc;
        bus.if_rsp_exc_code  = if_exc ? ifp_q.code : '0;
        bus.if_rsp_exc_val   = if_exc ? ifp_q.val : '0;
        bus.if_rsp_data      = (if_out && !ifp_q.fault) ? bus.mem_rdata : NOP;
        bus.ld_rsp_valid     = ldp_q.pend;
        bus.ld_rsp_err       = ldp_q.pend && ldp_q.err;
        bus.ld_rsp_data      = (ldp_q.pend && ldp_q.rd) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            starve_q <= '0;
            ifp_q    <= '0;
            ldp_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ifp_q    <= ifp_d;
            ldp_q    <= ldp_d;
        end
    end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter MEM_SIZE, default 2048: instruction memory depth in 32-bit words.
REQ-002 Parameter STARVE_MAX, default 4: consecutive loader wait cycles before forced loader grant.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Ports if_req_valid/if_req_ready, input/output, 1 each: fetch request handshake.
REQ-006 Port if_req_addr, input, 64: fetch PC (byte address).
REQ-007 Port if_flush, input, 1: discard fetch response in flight.
REQ-008 Ports if_rsp_valid, output, 1 / if_rsp_data, output, 32: fetch response, no backpressure.
REQ-009 Ports if_rsp_exc_en, output, 1 / if_rsp_exc_code, output, 4 / if_rsp_exc_val, output, 64: fetch fault report.
REQ-010 Ports ld_req_valid/ld_req_ready, input/output, 1 each: loader/debug request handshake.
REQ-011 Ports ld_req_we, input, 1 / ld_req_addr, input, 64 / ld_req_wdata, input, 32: loader write/read command.
REQ-012 Port ld_lock, input, 1: loader requests exclusive ownership of memory.
REQ-013 Ports ld_rsp_valid, output, 1 / ld_rsp_data, output, 32 / ld_rsp_err, output, 1: loader response.
REQ-014 Ports mem_en/mem_we, output, 1 each / mem_idx, output, clog2(MEM_SIZE) / mem_wdata, output, 32: memory command.
REQ-015 Port mem_rdata, input, 32: memory read data, valid exactly one cycle after mem_en && !mem_we.

Function
REQ-016 At most one request granted per cycle; grant = valid && ready on that port.
REQ-017 State machine RUN/LOCK: RUN->LOCK when ld_lock=1 and no fetch response pending; LOCK->RUN when ld_lock=0.
REQ-018 In LOCK: if_req_ready=0, ld_req_ready=1.
REQ-019 In RUN: fetch has priority; ld_req_ready=1 only when !if_req_valid, or when starve counter == STARVE_MAX (then if_req_ready=0).
REQ-020 Starve counter increments each RUN cycle with ld_req_valid && !ld grant, saturates at STARVE_MAX, clears on loader grant or !ld_req_valid.
REQ-021 Address check on granted request: misaligned if addr[1:0]!=0; out of range if addr[63:2] >= MEM_SIZE; misaligned takes precedence.
REQ-022 Legal granted request drives mem_en=1, mem_we=ld_req_we (0 for fetch), mem_idx=addr[2+:clog2(MEM_SIZE)] same cycle; illegal request drives mem_en=0.
REQ-023 Response latency exactly 1 cycle after grant for both ports, legal or faulted, reads and writes.
REQ-024 Fetch fault response: if_rsp_data=32'h00000013, if_rsp_exc_en=1, exc_code 0 (misaligned) or 1 (access fault), exc_val=faulting address, all for exactly one cycle.
REQ-025 Fetch legal response: if_rsp_data=mem_rdata, exc_en=0, exc_code=0, exc_val=0.
REQ-026 if_flush=1 in grant cycle or response cycle suppresses if_rsp_valid and exc_en for that response; if_flush does not block a new grant in the same cycle.
REQ-027 Loader fault: ld_rsp_err=1, ld_rsp_data=0, no memory write; loader write response carries ld_rsp_data=0.
REQ-028 Outputs when no response: if_rsp_data=32'h00000013, all other response fields 0.

Reset
REQ-029 rst_n=0 asynchronously forces state RUN, starve counter 0, pending flags 0, all rsp_valid/exc_en/err 0, mem_en/mem_we 0.
REQ-030 A grant made in the cycle reset asserts produces no response; first grant possible the cycle after rst_n rises.

Structure
REQ-031 Shared package holds exception code constants (EXC_IADDR_MISALIGN=0, EXC_IACCESS_FAULT=1), NOP encoding 32'h00000013 and RUN/LOCK state type.
REQ-032 One sub-module natural: imem_addr_chk (combinational misalign/range check, reused for both ports).

Verification
REQ-033 Fetch at 0x100 with mem word 0xDEADBEEF -> mem_idx=0x40 same cycle, if_rsp_valid=1 with data 0xDEADBEEF next cycle.
REQ-034 Fetch at 0x2000 (word 2048) -> mem_en=0, next cycle exc_en=1, code 1, exc_val=0x2000, data 0x13; one cycle only.
REQ-035 Fetch at 0x102 -> code 0, exc_val=0x102; address 0x1_0000_0000 -> code 1.
REQ-036 if_req_valid and ld_req_valid held high 6 cycles -> loader granted in cycle 5 (after 4 waits), counter cleared, fetch resumes cycle 6.
REQ-037 ld_lock=1 with writes of 0x11,0x22 to idx 0,1 -> if_req_ready=0 throughout; after unlock, fetches at 0x0/0x4 return 0x11/0x22.
REQ-038 rst_n low mid-grant -> no response next cycle, all outputs at reset values, state RUN.
